// File: rtl/ycbcr_skin_box.sv
// Skin-tone classifier on a YCbCr pixel stream.
// Produces a 1-cycle-delayed skin mask with matching sync/enable timing.
// Also tracks a per-frame bounding box and pixel count of the skin pixels.
// Results are published as a single-cycle pulse at each frame start.
module ycbcr_skin_box #(
    parameter int X_W     = 11,
    parameter int Y_W     = 11,
    parameter int CNT_W   = 21,
    parameter int CB_MIN  = 77,
    parameter int CB_MAX  = 127,
    parameter int CR_MIN  = 133,
    parameter int CR_MAX  = 173,
    parameter int MIN_PIX = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       i_y_8b,
    input  logic [7:0]       i_cb_8b,
    input  logic [7:0]       i_cr_8b,
    input  logic             i_h_sync,
    input  logic             i_v_sync,
    input  logic             i_data_en,
    output logic             o_mask,
    output logic             o_h_sync,
    output logic             o_v_sync,
    output logic             o_data_en,
    output logic             o_box_valid,
    output logic             o_box_found,
    output logic [X_W-1:0]   o_x_min,
    output logic [X_W-1:0]   o_x_max,
    output logic [Y_W-1:0]   o_y_min,
    output logic [Y_W-1:0]   o_y_max,
    output logic [CNT_W-1:0] o_pix_cnt
);

    localparam logic [7:0]       CB_LO   = 8'(CB_MIN);
    localparam logic [7:0]       CB_HI   = 8'(CB_MAX);
    localparam logic [7:0]       CR_LO   = 8'(CR_MIN);
    localparam logic [7:0]       CR_HI   = 8'(CR_MAX);
    localparam logic [CNT_W-1:0] PIX_THR = CNT_W'(MIN_PIX);

    // Luma is not used by the window classifier.
    logic unused_y;
    assign unused_y = ^i_y_8b;

    logic             v_prev_q, de_prev_q;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d, y_cur;
    logic [X_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
    logic [Y_W-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             skin, frame_start;

    logic             mask_q, hs_q, vs_q, de_q, bvalid_q, bfound_q;
    logic [X_W-1:0]   bxmin_q, bxmax_q;
    logic [Y_W-1:0]   bymin_q, bymax_q;
    logic [CNT_W-1:0] bcnt_q;

    // Pixel classification, frame start detection and the row seen by this pixel
    always_comb begin
        skin = i_data_en &&
               (i_cb_8b >= CB_LO) && (i_cb_8b <= CB_HI) &&
               (i_cr_8b >= CR_LO) && (i_cr_8b <= CR_HI);
        frame_start = i_v_sync && !v_prev_q;
        // A pixel arriving on the frame-start cycle already belongs to row 0.
        y_cur = frame_start ? '0 : y_q;
    end

    // Column/row counters: column runs during data_en, row advances at end of line
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!i_data_en) begin
            x_d = '0;
        end else if (x_q != '1) begin
            x_d = x_q + 1'b1;
        end
        if (frame_start) begin
            y_d = '0;
        end else if (de_prev_q && !i_data_en && (y_q != '1)) begin
            y_d = y_q + 1'b1;
        end
    end

    // Tracker update: re-init on frame start, then fold in the current skin pixel
    always_comb begin
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        cnt_d  = cnt_q;
        if (frame_start) begin
            xmin_d = '1;
            xmax_d = '0;
            ymin_d = '1;
            ymax_d = '0;
            cnt_d  = '0;
        end
        if (skin) begin
            if (x_q < xmin_d)   xmin_d = x_q;
            if (x_q > xmax_d)   xmax_d = x_q;
            if (y_cur < ymin_d) ymin_d = y_cur;
            if (y_cur > ymax_d) ymax_d = y_cur;
            if (cnt_d != '1)    cnt_d  = cnt_d + 1'b1;
        end
    end

    // Counter, history and tracker state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_prev_q  <= 1'b0;
            de_prev_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            xmin_q    <= '1;
            xmax_q    <= '0;
            ymin_q    <= '1;
            ymax_q    <= '0;
            cnt_q     <= '0;
        end else begin
            v_prev_q  <= i_v_sync;
            de_prev_q <= i_data_en;
            x_q       <= x_d;
            y_q       <= y_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            cnt_q     <= cnt_d;
        end
    end

    // Output stage: delayed mask/timing and box results latched at frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            de_q     <= 1'b0;
            bvalid_q <= 1'b0;
            bfound_q <= 1'b0;
            bxmin_q  <= '0;
            bxmax_q  <= '0;
            bymin_q  <= '0;
            bymax_q  <= '0;
            bcnt_q   <= '0;
        end else begin
            mask_q   <= skin;
            hs_q     <= i_h_sync;
            vs_q     <= i_v_sync;
            de_q     <= i_data_en;
            bvalid_q <= frame_start;
            if (frame_start) begin
                bfound_q <= (cnt_q >= PIX_THR);
                bxmin_q  <= xmin_q;
                bxmax_q  <= xmax_q;
                bymin_q  <= ymin_q;
                bymax_q  <= ymax_q;
                bcnt_q   <= cnt_q;
            end
        end
    end

    assign o_mask      = mask_q;
    assign o_h_sync    = hs_q;
    assign o_v_sync    = vs_q;
    assign o_data_en   = de_q;
    assign o_box_valid = bvalid_q;
    assign o_box_found = bfound_q;
    assign o_x_min     = bxmin_q;
    assign o_x_max     = bxmax_q;
    assign o_y_min     = bymin_q;
    assign o_y_max     = bymax_q;
    assign o_pix_cnt   = bcnt_q;

endmodule

// File: tb/tb_ycbcr_skin_box.sv
// Testbench for ycbcr_skin_box: two instances (MIN_PIX=10 and 64) on a shared stream,
// checked against a frame-level reference model built from stored skin coordinates.
module tb_ycbcr_skin_box;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  y_i = 8'd0, cb_i = 8'd0, cr_i = 8'd0;
    logic        hs_i = 1'b0, vs_i = 1'b0, de_i = 1'b0;

    logic        a_mask, a_hs, a_vs, a_de, a_bv, a_bf;
    logic [10:0] a_xmin, a_xmax, a_ymin, a_ymax;
    logic [20:0] a_cnt;
    logic        b_mask, b_hs, b_vs, b_de, b_bv, b_bf;
    logic [10:0] b_xmin, b_xmax, b_ymin, b_ymax;
    logic [20:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ycbcr_skin_box #(.MIN_PIX(10)) dut (
        .clk(clk), .rst_n(rst_n), .i_y_8b(y_i), .i_cb_8b(cb_i), .i_cr_8b(cr_i),
        .i_h_sync(hs_i), .i_v_sync(vs_i), .i_data_en(de_i),
        .o_mask(a_mask), .o_h_sync(a_hs), .o_v_sync(a_vs), .o_data_en(a_de),
        .o_box_valid(a_bv), .o_box_found(a_bf), .o_x_min(a_xmin), .o_x_max(a_xmax),
        .o_y_min(a_ymin), .o_y_max(a_ymax), .o_pix_cnt(a_cnt)
    );

    ycbcr_skin_box #(.MIN_PIX(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .i_y_8b(y_i), .i_cb_8b(cb_i), .i_cr_8b(cr_i),
        .i_h_sync(hs_i), .i_v_sync(vs_i), .i_data_en(de_i),
        .o_mask(b_mask), .o_h_sync(b_hs), .o_v_sync(b_vs), .o_data_en(b_de),
        .o_box_valid(b_bv), .o_box_found(b_bf), .o_x_min(b_xmin), .o_x_max(b_xmax),
        .o_y_min(b_ymin), .o_y_max(b_ymax), .o_pix_cnt(b_cnt)
    );

    // Reference model: skin pixel coordinates of the current frame, box derived at frame start
    typedef struct { int x; int y; } pt_t;
    pt_t pts[$];
    int  m_col, m_row;
    bit  m_vprev, m_deprev;
    int  e_mask, e_hs, e_vs, e_de, e_bv, e_bf10, e_bf64;
    int  e_xmin, e_xmax, e_ymin, e_ymax, e_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pts.delete();
        m_col = 0; m_row = 0; m_vprev = 0; m_deprev = 0;
        e_mask = 0; e_hs = 0; e_vs = 0; e_de = 0; e_bv = 0; e_bf10 = 0; e_bf64 = 0;
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0;
    endtask

    task automatic model_cycle();
        bit fs, skin;
        int row;
        fs   = vs_i && !m_vprev;
        skin = de_i && cb_i >= 77 && cb_i <= 127 && cr_i >= 133 && cr_i <= 173;
        row  = fs ? 0 : m_row;
        e_bv = fs;
        if (fs) begin
            e_xmin = 2047; e_xmax = 0; e_ymin = 2047; e_ymax = 0;
            foreach (pts[i]) begin
                if (pts[i].x < e_xmin) e_xmin = pts[i].x;
                if (pts[i].x > e_xmax) e_xmax = pts[i].x;
                if (pts[i].y < e_ymin) e_ymin = pts[i].y;
                if (pts[i].y > e_ymax) e_ymax = pts[i].y;
            end
            e_cnt  = pts.size();
            e_bf10 = (e_cnt >= 10);
            e_bf64 = (e_cnt >= 64);
            pts.delete();
        end
        if (skin) pts.push_back('{x: m_col, y: row});
        e_mask = skin; e_hs = hs_i; e_vs = vs_i; e_de = de_i;
        if (fs) m_row = 0;
        else if (m_deprev && !de_i) m_row = (m_row < 2047) ? m_row + 1 : 2047;
        m_col   = de_i ? ((m_col < 2047) ? m_col + 1 : 2047) : 0;
        m_vprev = vs_i;
        m_deprev = de_i;
    endtask

    task automatic check_all();
        chk("mask", a_mask, e_mask);       chk("mask64", b_mask, e_mask);
        chk("hsync", a_hs, e_hs);          chk("vsync", a_vs, e_vs);
        chk("de", a_de, e_de);             chk("de64", b_de, e_de);
        chk("box_valid", a_bv, e_bv);      chk("box_valid64", b_bv, e_bv);
        chk("found10", a_bf, e_bf10);      chk("found64", b_bf, e_bf64);
        chk("x_min", a_xmin, e_xmin);      chk("x_max", a_xmax, e_xmax);
        chk("y_min", a_ymin, e_ymin);      chk("y_max", a_ymax, e_ymax);
        chk("pix_cnt", a_cnt, e_cnt);      chk("pix_cnt64", b_cnt, e_cnt);
        chk("x_min64", b_xmin, e_xmin);    chk("y_max64", b_ymax, e_ymax);
    endtask

    // Called at a negedge: apply inputs, advance the model, clock, check, return at negedge
    task automatic step(input bit v, input bit h, input bit de, input int cb, input int cr);
        vs_i = v; hs_i = h; de_i = de; cb_i = 8'(cb); cr_i = 8'(cr); y_i = 8'($urandom);
        model_cycle();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mask"}, a_mask, 0);  chk({tag, "_hs"}, a_hs, 0);
        chk({tag, "_vs"}, a_vs, 0);      chk({tag, "_de"}, a_de, 0);
        chk({tag, "_bv"}, a_bv, 0);      chk({tag, "_bf"}, a_bf, 0);
        chk({tag, "_xmin"}, a_xmin, 0);  chk({tag, "_xmax"}, a_xmax, 0);
        chk({tag, "_ymin"}, a_ymin, 0);  chk({tag, "_ymax"}, a_ymax, 0);
        chk({tag, "_cnt"}, a_cnt, 0);    chk({tag, "_bv64"}, b_bv, 0);
    endtask

    // Frame of w x h active pixels; skin block at cols x0..x1, rows y0..y1
    task automatic run_frame(input int w, input int h, input int x0, input int x1,
                             input int y0, input int y1);
        for (int r = 0; r < h; r++) begin
            step(0, 1, 0, 0, 0);
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 100, 150);
            for (int c = 0; c < w; c++) begin
                if (c >= x0 && c <= x1 && r >= y0 && r <= y1) step(0, 0, 1, 100, 150);
                else step(0, 0, 1, 50, 200);
            end
        end
        step(0, 0, 0, 0, 0);
    endtask

    // Vertical sync held for n cycles; results visible after the first cycle
    task automatic vsync_first();
        step(1, 0, 0, 0, 0);
        chk("vs_pulse", a_bv, 1);
    endtask

    task automatic vsync_rest(input int n);
        for (int i = 1; i < n; i++) begin
            step(1, 0, 0, 0, 0);
            chk("vs_single", a_bv, 0);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);

        // First frame start after reset reports an empty frame
        vsync_first();
        chk("first_found", a_bf, 0);   chk("first_xmin", a_xmin, 2047);
        chk("first_xmax", a_xmax, 0);  chk("first_cnt", a_cnt, 0);
        vsync_rest(3);

        // Threshold edges
        step(0, 0, 1, 77, 133);  chk("thr_77_133", a_mask, 1);
        step(0, 0, 1, 76, 133);  chk("thr_cb76", a_mask, 0);
        step(0, 0, 1, 127, 174); chk("thr_cr174", a_mask, 0);
        step(0, 0, 1, 127, 173); chk("thr_127_173", a_mask, 1);
        step(0, 0, 1, 128, 150); chk("thr_cb128", a_mask, 0);
        step(0, 0, 1, 100, 132); chk("thr_cr132", a_mask, 0);
        step(0, 0, 0, 100, 150); chk("thr_de0", a_mask, 0);
        step(0, 0, 0, 0, 0);
        vsync_first();
        vsync_rest(2);

        // 16x8 frame, skin block cols 3..6 rows 2..4
        run_frame(16, 8, 3, 6, 2, 4);
        vsync_first();
        chk("box_xmin", a_xmin, 3);  chk("box_xmax", a_xmax, 6);
        chk("box_ymin", a_ymin, 2);  chk("box_ymax", a_ymax, 4);
        chk("box_cnt", a_cnt, 12);   chk("box_found10", a_bf, 1);
        chk("box_found64", b_bf, 0); chk("box_cnt64", b_cnt, 12);
        chk("box_xmin64", b_xmin, 3); chk("box_ymax64", b_ymax, 4);
        vsync_rest(4);

        // Empty frame
        run_frame(16, 4, 99, 99, 99, 99);
        vsync_first();
        chk("empty_xmin", a_xmin, 2047); chk("empty_xmax", a_xmax, 0);
        chk("empty_ymin", a_ymin, 2047); chk("empty_ymax", a_ymax, 0);
        chk("empty_cnt", a_cnt, 0);      chk("empty_found", a_bf, 0);
        vsync_rest(2);

        // Skin pixel coincident with frame start belongs to the new frame at row 0
        run_frame(8, 2, 0, 7, 0, 1);
        step(0, 0, 1, 50, 200);
        step(1, 0, 1, 100, 150);
        chk("coin_cnt", a_cnt, 16);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        vsync_first();
        chk("coin_new_xmin", a_xmin, 1); chk("coin_new_ymax", a_ymax, 0);
        chk("coin_new_cnt", a_cnt, 1);
        vsync_rest(2);

        // Randomised sync / enable / colour stream
        for (int i = 0; i < 4000; i++) begin
            bit v, h, de;
            v  = ($urandom_range(0, 99) < 3) ? 1'b1 : (m_vprev && $urandom_range(0, 1) == 1);
            h  = ($urandom_range(0, 9) == 0);
            de = ($urandom_range(0, 9) < 7);
            step(v, h, de, $urandom_range(60, 140), $urandom_range(120, 185));
        end
        step(0, 0, 0, 0, 0);

        // Reset mid-frame: immediate clear, next frame start reports empty
        run_frame(10, 3, 2, 5, 0, 2);
        step(0, 0, 1, 100, 150);
        rst_n = 1'b0;
        de_i = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("midrst_novalid", a_bv, 0);
        vsync_first();
        chk("midrst_xmin", a_xmin, 2047); chk("midrst_cnt", a_cnt, 0);
        chk("midrst_found", a_bf, 0);
        vsync_rest(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
